multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the 8-bit, 2-bit-opcode processor datapath (instruction fetch, register file, execute/writeback).
- Replaces the single-cycle combinational control unit.
- Fetches each instruction over a ready/req handshake, holds it in an instruction register, then drives PCSrc, RegWrite, ALUSrc and ImmSel phase by phase.
- Adds run/single-step/halt control and a fetch-timeout fault.

Parameters:
- FETCH_TIMEOUT, 16: maximum FETCH wait cycles with IMem_Ready low before FAULT (valid range 1..255).
- CNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- Clk, input, 1: clock; all logic is rising-edge.
- Reset, input, 1: synchronous, active-high reset.
- Run, input, 1: level; continuous execution while high.
- Step, input, 1: pulse; executes one instruction when sampled in IDLE with Run=0.
- IMem_Ready, input, 1: instruction memory has valid data on Instruction_In this cycle.
- Instruction_In, input, 8: fetched instruction.
- IMem_Req, output, 1: fetch request.
- IR, output, 8: instruction register; feeds opcode [7:6] and register/immediate fields [5:0].
- IR_Write, output, 1: one-cycle pulse when IR loads.
- PC_Write, output, 1: one-cycle PC update enable.
- PCSrc, output, 1: 1 = PC+offset, 0 = PC+1.
- RegWrite, output, 1: register file write enable.
- ALUSrc, output, 1: 1 = immediate operand, 0 = register.
- ImmSel, output, 1: immediate select to register file.
- State, output, 3: current state code (debug).
- Halted, output, 1: in HALT.
- Fault, output, 1: in FAULT.
- Instr_Count, output, CNT_WIDTH: retired instructions.

Behaviour:
- Reset (sync, highest priority, any state) forces:
  - State=IDLE, IR=8'h00, Instr_Count=0, timeout counter=0, step latch=0.
  - All control outputs 0.
  - Applies mid-fetch and mid-instruction; no partial retirement.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, FAULT=6. Code 7 is unreachable and goes to FAULT.
- IDLE:
  - Run=1 → FETCH.
  - Else Step=1 → FETCH with step latch set.
  - Run and Step both high → Run wins; step latch stays 0.
- FETCH:
  - IMem_Req=1.
  - IMem_Ready=1 → IR<=Instruction_In, IR_Write=1 this cycle, timeout counter cleared, → DECODE.
  - Else the timeout counter increments. When it reaches FETCH_TIMEOUT → FAULT.
  - Ready in the same cycle the count would hit the limit: fetch succeeds.
- DECODE: one cycle, no outputs. Classifies IR[7:6]:
  - 00 ADD: register + register.
  - 01 ADDI: register + sign-extended immediate.
  - 10 JMP: PC += signed IR[5:0].
  - 11 with IR[5:0]=6'h3F: HALT.
  - Any other 11: NOP.
- EXECUTE:
  - ALUSrc=1 and ImmSel=1 for ADDI; both 0 otherwise.
  - JMP: PC_Write=1 and PCSrc=1, retire, skip WRITEBACK.
  - HALT: → HALT without PC_Write, Instr_Count unchanged.
  - Others: → WRITEBACK.
- WRITEBACK:
  - ALUSrc and ImmSel held from EXECUTE.
  - RegWrite=1 for ADD/ADDI only.
  - PC_Write=1, PCSrc=0. Retire.
- Retirement (exactly one PC_Write pulse per instruction):
  - Instr_Count+1, wrapping modulo 2^CNT_WIDTH.
  - Next state: FETCH if Run=1; IDLE if Run=0 or the step latch is set. The step latch clears on retirement.
  - Run dropping mid-instruction completes the current instruction, then → IDLE.
- HALT and FAULT are sticky; only Reset exits. In both, all control outputs are 0 and Run/Step are ignored.
- Latency with IMem_Ready already high:
  - ADD/ADDI/NOP: 4 cycles per instruction.
  - JMP: 3 cycles.
  - Each cycle of Ready low in FETCH adds one cycle.
- IMem_Req is asserted only in FETCH. RegWrite and PC_Write never assert in the same instruction except in WRITEBACK. RegWrite never asserts for JMP, NOP or HALT.

Test Plan:
1. Reset, Run=1, Ready always 1, fetch 8'b00_001_010 (ADD) → IR_Write in cycle 1; RegWrite=1, ALUSrc=0, PC_Write=1, PCSrc=0 in cycle 4; Instr_Count=1; next cycle FETCH.
2. Run=1 with sequence ADDI 8'h4B, JMP 8'hBE (offset −2), HALT 8'hFF:
   - ADDI: ALUSrc=ImmSel=1 in cycles 3–4.
   - JMP: PC_Write=PCSrc=1 at its EXECUTE, no WRITEBACK, 3 cycles.
   - HALT: Halted=1, Instr_Count=2, stays halted with Run=1 for 20 cycles.
3. Run=0, Step pulse in IDLE → exactly one instruction retires, back to IDLE, Instr_Count=1. A second Step gives count 2. Run=1 together with Step gives continuous execution.
4. FETCH_TIMEOUT=4, Ready held low → Fault=1 after 4 wait cycles. Ready arriving on wait cycle 4 instead → normal DECODE. Fault clears only on Reset.
5. Reset asserted during EXECUTE of ADD → next cycle State=0, IR=0, RegWrite and PC_Write never pulsed, Instr_Count=0.
6. CNT_WIDTH=4: retire 17 NOPs (8'hC0) → Instr_Count wraps to 1. Run dropped during DECODE of the 17th → completes, then IDLE.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle sequencer for the 8-bit, 2-bit-opcode processor datapath.
// Each instruction is fetched over a req/ready handshake, held in IR, then
// walked through DECODE, EXECUTE and (except for JMP/HALT) WRITEBACK while the
// datapath controls are driven phase by phase. Run gives continuous execution,
// Step a single instruction from IDLE. HALT and FAULT are sticky until Reset.
//
// Ports:
//   Clk            rising-edge clock
//   Reset          synchronous, active-high reset (highest priority)
//   Run            level: execute continuously while high
//   Step           pulse: execute one instruction when seen in IDLE with Run=0
//   IMem_Ready     instruction memory presents valid data this cycle
//   Instruction_In fetched instruction
//   IMem_Req       fetch request (FETCH only)
//   IR             instruction register: opcode [7:6], fields [5:0]
//   IR_Write       high in the FETCH cycle whose edge loads IR
//   PC_Write       one-cycle PC update enable (exactly one per instruction)
//   PCSrc          1 = PC+offset, 0 = PC+1
//   RegWrite       register file write enable (ADD/ADDI writeback)
//   ALUSrc         1 = immediate operand, 0 = register operand
//   ImmSel         immediate select to register file
//   State          current state code (debug)
//   Halted         in HALT
//   Fault          in FAULT (fetch timeout or illegal state)
//   Instr_Count    retired instructions, wraps modulo 2**CNT_WIDTH
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 Step,
    input  logic                 IMem_Ready,
    input  logic [7:0]           Instruction_In,
    output logic                 IMem_Req,
    output logic [7:0]           IR,
    output logic                 IR_Write,
    output logic                 PC_Write,
    output logic                 PCSrc,
    output logic                 RegWrite,
    output logic                 ALUSrc,
    output logic                 ImmSel,
    output logic [2:0]           State,
    output logic                 Halted,
    output logic                 Fault,
    output logic [CNT_WIDTH-1:0] Instr_Count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_FAULT     = 3'd6,
        ST_ILLEGAL   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_JMP  = 3'd2,
        OP_HALT = 3'd3,
        OP_NOP  = 3'd4
    } op_e;

    localparam logic [7:0]           TMO_LIMIT = 8'(FETCH_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    // Opcode classification of the instruction register.
    function automatic op_e classify(input logic [7:0] instr);
        op_e op;
        case (instr[7:6])
            2'b00:   op = OP_ADD;
            2'b01:   op = OP_ADDI;
            2'b10:   op = OP_JMP;
            2'b11:   op = (instr[5:0] == 6'h3F) ? OP_HALT : OP_NOP;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    state_e                state_q, state_d;
    logic [7:0]            ir_q, ir_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  step_q, step_d;
    logic                  imem_req_q, imem_req_d;
    logic                  pc_write_q, pc_write_d;
    logic                  pc_src_q, pc_src_d;
    logic                  reg_write_q, reg_write_d;
    logic                  alu_src_q, alu_src_d;
    logic                  imm_sel_q, imm_sel_d;
    logic                  halted_q, halted_d;
    logic                  fault_q, fault_d;
    logic                  retire_s;
    op_e                   op_s;

    // IR is stable from DECODE onward, so the class is taken straight from it.
    assign op_s = classify(ir_q);

    // Next-state, instruction register, counters and step latch.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        tmo_d    = 8'd0;
        step_d   = step_q;
        retire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Run) begin
                    state_d = ST_FETCH;
                end else if (Step) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // A ready arriving on the cycle the limit would be hit still wins.
                if (IMem_Ready) begin
                    ir_d    = Instruction_In;
                    state_d = ST_DECODE;
                end else if ((tmo_q + 8'd1) == TMO_LIMIT) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d   = tmo_q + 8'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (op_s)
                    OP_JMP:  retire_s = 1'b1;
                    OP_HALT: state_d  = ST_HALT;
                    default: state_d  = ST_WRITEBACK;
                endcase
            end
            ST_WRITEBACK: begin
                retire_s = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
        // A stepped instruction always returns to IDLE, even if Run rose meanwhile.
        if (retire_s) begin
            cnt_d   = cnt_q + CNT_ONE;
            step_d  = 1'b0;
            state_d = (Run && !step_q) ? ST_FETCH : ST_IDLE;
        end else begin
            cnt_d   = cnt_q;
        end
    end

    // Control outputs are decoded from the state being entered so they are
    // registered and line up with that state's cycle.
    always_comb begin
        imem_req_d  = (state_d == ST_FETCH);
        pc_write_d  = (state_d == ST_WRITEBACK) ||
                      ((state_d == ST_EXECUTE) && (op_s == OP_JMP));
        pc_src_d    = (state_d == ST_EXECUTE) && (op_s == OP_JMP);
        reg_write_d = (state_d == ST_WRITEBACK) &&
                      ((op_s == OP_ADD) || (op_s == OP_ADDI));
        alu_src_d   = ((state_d == ST_EXECUTE) || (state_d == ST_WRITEBACK)) &&
                      (op_s == OP_ADDI);
        imm_sel_d   = alu_src_d;
        halted_d    = (state_d == ST_HALT);
        fault_d     = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= 8'h00;
            cnt_q       <= {CNT_WIDTH{1'b0}};
            tmo_q       <= 8'd0;
            step_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            pc_write_q  <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            imm_sel_q   <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            step_q      <= step_d;
            imem_req_q  <= imem_req_d;
            pc_write_q  <= pc_write_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            alu_src_q   <= alu_src_d;
            imm_sel_q   <= imm_sel_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

    // IR_Write marks the cycle whose closing edge loads IR; Reset suppresses it.
    assign IR_Write    = (state_q == ST_FETCH) && IMem_Ready && !Reset;
    assign IMem_Req    = imem_req_q;
    assign IR          = ir_q;
    assign PC_Write    = pc_write_q;
    assign PCSrc       = pc_src_q;
    assign RegWrite    = reg_write_q;
    assign ALUSrc      = alu_src_q;
    assign ImmSel      = imm_sel_q;
    assign State       = state_q;
    assign Halted      = halted_q;
    assign Fault       = fault_q;
    assign Instr_Count = cnt_q;

endmodule
